// File: rtl/traffic_pkg.sv
// Shared definitions for the four-way junction controller and its downstream lamp decoder.
// Phase encodings, lamp vector type and default timings live here so both ends agree.
package traffic_pkg;

  localparam logic [2:0] RED_B    = 3'd0;
  localparam logic [2:0] A_GREEN  = 3'd1;
  localparam logic [2:0] A_YELLOW = 3'd2;
  localparam logic [2:0] RED_A    = 3'd3;
  localparam logic [2:0] B_GREEN  = 3'd4;
  localparam logic [2:0] B_YELLOW = 3'd5;

  typedef struct packed {
    logic r;
    logic g;
    logic y;
  } lamp_t;

  localparam int DEF_GREEN_T  = 30;
  localparam int DEF_YELLOW_T = 15;
  localparam int DEF_ALLRED_T = 2;

  // Counter wide enough for the longest phase's terminal value, never narrower than 1 bit.
  function automatic int cnt_width(input int g, input int y, input int r);
    int m;
    m = g;
    if (y > m) m = y;
    if (r > m) m = r;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/traffic_ctrl_four_phase_timer.sv
// Saturating phase counter: cleared by the FSM on each state change, holds at the terminal value.
module phase_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         done
);

  assign done = (cnt == term);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (!done) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/traffic_ctrl_four.sv
// Four-way junction lamp controller: fixed phase rotation, demand latches and sensor-driven green extension.
module traffic_ctrl_four
  import traffic_pkg::*;
#(
  parameter int GREEN_T  = DEF_GREEN_T,
  parameter int YELLOW_T = DEF_YELLOW_T,
  parameter int ALLRED_T = DEF_ALLRED_T
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_sensor,
  input  logic       b_sensor,
  output logic       ar,
  output logic       ag,
  output logic       ay,
  output logic       br,
  output logic       bg,
  output logic       by,
  output logic [2:0] phase
);

  localparam int CW = cnt_width(GREEN_T, YELLOW_T, ALLRED_T);
  localparam logic [CW-1:0] G_TERM = CW'(GREEN_T - 1);
  localparam logic [CW-1:0] Y_TERM = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] R_TERM = CW'(ALLRED_T - 1);

  logic [2:0]    state;
  logic [2:0]    next_state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] term;
  logic          done;
  logic          leave;
  logic          a_req;
  logic          b_req;
  lamp_t         lamp_a;
  lamp_t         lamp_b;

  always_comb begin
    term = R_TERM;
    case (state)
      A_GREEN, B_GREEN:   term = G_TERM;
      A_YELLOW, B_YELLOW: term = Y_TERM;
      default:            term = R_TERM;
    endcase
  end

  phase_timer #(.W(CW)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (leave),
    .term  (term),
    .cnt   (cnt),
    .done  (done)
  );

  // Greens only yield once crossing demand exists, latched or live this cycle.
  always_comb begin
    next_state = state;
    case (state)
      RED_B:    if (done) next_state = A_GREEN;
      A_GREEN:  if (done && (b_req || b_sensor)) next_state = A_YELLOW;
      A_YELLOW: if (done) next_state = RED_A;
      RED_A:    if (done) next_state = B_GREEN;
      B_GREEN:  if (done && (a_req || a_sensor)) next_state = B_YELLOW;
      B_YELLOW: if (done) next_state = RED_B;
      default:  next_state = RED_B;
    endcase
    leave = (next_state != state);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RED_B;
    end else begin
      state <= next_state;
    end
  end

  // Entering a green serves that side's request, overriding a same-cycle set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_req <= 1'b0;
      b_req <= 1'b0;
    end else begin
      if (leave && next_state == A_GREEN) a_req <= 1'b0;
      else if (a_sensor && state != A_GREEN) a_req <= 1'b1;
      if (leave && next_state == B_GREEN) b_req <= 1'b0;
      else if (b_sensor && state != B_GREEN) b_req <= 1'b1;
    end
  end

  always_comb begin
    lamp_a = '{r: 1'b1, g: 1'b0, y: 1'b0};
    lamp_b = '{r: 1'b1, g: 1'b0, y: 1'b0};
    case (state)
      A_GREEN:  lamp_a = '{r: 1'b0, g: 1'b1, y: 1'b0};
      A_YELLOW: lamp_a = '{r: 1'b0, g: 1'b0, y: 1'b1};
      B_GREEN:  lamp_b = '{r: 1'b0, g: 1'b1, y: 1'b0};
      B_YELLOW: lamp_b = '{r: 1'b0, g: 1'b0, y: 1'b1};
      default: begin
        lamp_a = '{r: 1'b1, g: 1'b0, y: 1'b0};
        lamp_b = '{r: 1'b1, g: 1'b0, y: 1'b0};
      end
    endcase
  end

  assign {ar, ag, ay} = lamp_a;
  assign {br, bg, by} = lamp_b;
  assign phase        = state;

endmodule

// File: tb/tb_traffic_ctrl_four.sv
// Bench for traffic_ctrl_four: directed junction scenarios followed by random sensor traffic,
// all compared each cycle against a phase/duration model of the junction.
module tb_traffic_ctrl_four;

  localparam int G = 4;
  localparam int Y = 2;
  localparam int R = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_sensor = 1'b0;
  logic       b_sensor = 1'b0;
  logic       ar, ag, ay, br, bg, by;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;

  // Reference: phase index 0..5 in rotation order, cycles spent in it, pending demand.
  int m_phase;
  int m_age;
  bit m_areq;
  bit m_breq;
  int dur [6] = '{R, G, Y, R, G, Y};
  int seq [14] = '{0, 1, 1, 1, 1, 2, 2, 3, 4, 4, 4, 4, 5, 5};

  traffic_ctrl_four #(
    .GREEN_T  (G),
    .YELLOW_T (Y),
    .ALLRED_T (R)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_sensor (a_sensor),
    .b_sensor (b_sensor),
    .ar       (ar),
    .ag       (ag),
    .ay       (ay),
    .br       (br),
    .bg       (bg),
    .by       (by),
    .phase    (phase)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_age   = 0;
    m_areq  = 1'b0;
    m_breq  = 1'b0;
  endtask

  // One clock edge of the junction rules, given the sensor levels seen before the edge.
  task automatic model_edge(input bit sa, input bit sb);
    bit min_met;
    bit go;
    int nxt;
    min_met = (m_age >= dur[m_phase] - 1);
    if (m_phase == 1)      go = min_met && (m_breq || sb);
    else if (m_phase == 4) go = min_met && (m_areq || sa);
    else                   go = min_met;
    nxt = go ? (m_phase + 1) % 6 : m_phase;
    if (sa && m_phase != 1) m_areq = 1'b1;
    if (sb && m_phase != 4) m_breq = 1'b1;
    if (go && nxt == 1) m_areq = 1'b0;
    if (go && nxt == 4) m_breq = 1'b0;
    m_age   = go ? 0 : m_age + 1;
    m_phase = nxt;
  endtask

  task automatic check_model(input string tag);
    int  exp_cnt;
    bit  e_ag, e_ay, e_bg, e_by;
    exp_cnt = (m_age < dur[m_phase] - 1) ? m_age : dur[m_phase] - 1;
    e_ag = (m_phase == 1);
    e_ay = (m_phase == 2);
    e_bg = (m_phase == 4);
    e_by = (m_phase == 5);
    check_output({tag, ":phase"}, phase, m_phase);
    check_output({tag, ":ar"}, ar, !(e_ag || e_ay));
    check_output({tag, ":ag"}, ag, e_ag);
    check_output({tag, ":ay"}, ay, e_ay);
    check_output({tag, ":br"}, br, !(e_bg || e_by));
    check_output({tag, ":bg"}, bg, e_bg);
    check_output({tag, ":by"}, by, e_by);
    check_output({tag, ":cnt"}, dut.cnt, exp_cnt);
    check_output({tag, ":a_req"}, dut.a_req, m_areq);
    check_output({tag, ":b_req"}, dut.b_req, m_breq);
    check_output({tag, ":no_dual_green"}, ag & bg, 1'b0);
  endtask

  task automatic apply_stimulus(input bit sa, input bit sb);
    a_sensor = sa;
    b_sensor = sb;
    @(posedge clk);
    model_edge(sa, sb);
    #1;
    check_model("step");
  endtask

  // Called 1 time unit after an edge; reset asserts and releases between edges.
  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model("reset");
    #2;
    rst_n = 1'b1;
  endtask

  task automatic wait_phase(input int p, input string tag);
    int n;
    n = 0;
    while (phase !== 3'(p) && n < 30) begin
      apply_stimulus(1'b0, 1'b0);
      n++;
    end
    check_output(tag, phase, p);
  endtask

  initial begin
    #1;
    model_reset();
    check_model("por");
    #2;
    rst_n = 1'b1;

    // Both sides always demanding: plain 14-cycle alternation.
    for (int k = 1; k <= 28; k++) begin
      apply_stimulus(1'b1, 1'b1);
      check_output("s1_seq", phase, seq[k % 14]);
    end

    // No crossing demand: A green holds with a saturated counter.
    apply_reset();
    for (int k = 0; k < 21; k++) apply_stimulus(1'b0, 1'b0);
    check_output("s2_hold_phase", phase, 1);
    check_output("s2_hold_ag", ag, 1'b1);
    check_output("s2_cnt_sat", dut.cnt, G - 1);

    // One-cycle B pulse ends the saturated green on the next edge.
    apply_stimulus(1'b0, 1'b1);
    check_output("s3_yellow", phase, 2);
    for (int k = 0; k < 3; k++) apply_stimulus(1'b0, 1'b0);
    check_output("s3_b_green", phase, 4);
    for (int k = 0; k < 6; k++) apply_stimulus(1'b0, 1'b0);

    // Early B pulse in A green is latched but green still runs its minimum length.
    apply_stimulus(1'b1, 1'b0);
    check_output("s4_b_yellow", phase, 5);
    wait_phase(1, "s4_reach_a_green");
    apply_stimulus(1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b0);
    check_output("s4_green_held", phase, 1);
    apply_stimulus(1'b0, 1'b0);
    check_output("s4_yellow", phase, 2);

    // Asynchronous reset in B green, then one all-red cycle before A green.
    wait_phase(4, "s5_reach_b_green");
    apply_reset();
    apply_stimulus(1'b0, 1'b0);
    check_output("s5_a_green", phase, 1);

    // A sensor held through A green entry: the clear wins and no request remains.
    apply_reset();
    apply_stimulus(1'b1, 1'b0);
    check_output("s6_entry", phase, 1);
    check_output("s6_clear_wins", dut.a_req, 1'b0);
    for (int k = 0; k < 5; k++) apply_stimulus(1'b1, 1'b0);
    check_output("s6_hold", phase, 1);
    check_output("s6_no_req", dut.a_req, 1'b0);
    apply_stimulus(1'b0, 1'b1);
    check_output("s6_yellow", phase, 2);

    // Sparse random traffic exercises extensions and latched demand together.
    for (int k = 0; k < 300; k++) begin
      apply_stimulus($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
